// File: rtl/pe_mac_lane_if.sv
// Bus bundle for pe_mac_lane: configuration, data/weight streams, systolic
// forwarding and the ready/valid result port.
interface pe_mac_lane_if #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int LANES = 4,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0]       cfg_acc_len;
  logic [4:0]             cfg_shift;
  logic                   cfg_relu;
  logic                   data_valid;
  logic [DW-1:0]          data;
  logic                   weight_valid;
  logic [LANES*WW-1:0]    weight;
  logic                   weight_swap;
  logic [DW-1:0]          data_out;
  logic                   data_out_valid;
  logic [LANES*OUT_W-1:0] sum_out;
  logic                   sum_valid;
  logic                   out_ready;
  logic                   swap_pending;
  logic                   ovf_sticky;

  modport master (
    output cfg_acc_len, cfg_shift, cfg_relu, data_valid, data,
           weight_valid, weight, weight_swap, out_ready,
    input  data_out, data_out_valid, sum_out, sum_valid,
           swap_pending, ovf_sticky
  );

  modport slave (
    input  cfg_acc_len, cfg_shift, cfg_relu, data_valid, data,
           weight_valid, weight, weight_swap, out_ready,
    output data_out, data_out_valid, sum_out, sum_valid,
           swap_pending, ovf_sticky
  );
endinterface

// File: rtl/pe_mac_lane.sv
// Multi-lane MAC processing element: one broadcast data stream, LANES signed
// weights, windowed accumulation with round/shift/ReLU/saturate post-processing.
module pe_mac_lane #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  pe_mac_lane_if.slave bus
);

  // Post-processing width: wide enough for the accumulator plus the largest
  // rounding constant (2^30) without wrapping.
  localparam int RW = ((ACC_W > 31) ? ACC_W : 31) + 2;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [DW-1:0]    data_reg;
  logic                    dv_reg;
  logic signed [WW-1:0]    shadow [LANES];
  logic signed [WW-1:0]    active [LANES];
  logic signed [ACC_W-1:0] acc    [LANES];
  logic [CNT_W-1:0]        cnt;
  logic [LANES*OUT_W-1:0]  sum_reg;
  logic                    sum_valid_r;
  logic                    swap_pending_r;
  logic                    ovf_r;

  logic [CNT_W-1:0]        len_eff;
  logic [CNT_W:0]          cnt_inc;
  logic                    is_final;
  logic                    swap_req;
  logic                    swap_ok;
  logic signed [ACC_W-1:0] result [LANES];
  logic [LANES*OUT_W-1:0]  sat_packed;

  function automatic logic [OUT_W-1:0] post_process(
    input logic signed [ACC_W-1:0] r,
    input logic [4:0]              sh,
    input logic                    relu
  );
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] shifted;
    rnd     = (sh == 5'd0) ? '0 : (RW'(1) <<< (sh - 5'd1));
    shifted = (RW'(r) + rnd) >>> sh;
    if (relu && shifted[RW-1]) shifted = '0;
    if (shifted > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return shifted[OUT_W-1:0];
  endfunction

  // Window control: a length of 0 behaves like 1.
  always_comb begin
    len_eff  = (bus.cfg_acc_len == '0) ? CNT_W'(1) : bus.cfg_acc_len;
    cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
    is_final = dv_reg && (cnt_inc >= {1'b0, len_eff});
    swap_req = bus.weight_swap || swap_pending_r;
    swap_ok  = ((cnt == '0) && !dv_reg) || is_final;
  end

  // NOTE: every variable assigned in always_comb gets a value on all paths
  // (defaults first) so no latch is inferred.
  always_comb begin
    sat_packed = '0;
    for (int i = 0; i < LANES; i++) begin
      result[i] = acc[i] + ACC_W'(data_reg) * ACC_W'(active[i]);
      sat_packed[i*OUT_W +: OUT_W] = post_process(result[i], bus.cfg_shift, bus.cfg_relu);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, e.g. active takes the old shadow on a load+swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      dv_reg   <= 1'b0;
    end else begin
      data_reg <= bus.data;
      dv_reg   <= bus.data_valid;
    end
  end

  // NOTE: the weight banks and accumulators are small register arrays, not
  // RAM, so they are cleared by reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        acc[i]    <= '0;
      end
      cnt            <= '0;
      swap_pending_r <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.weight_valid) shadow[i] <= bus.weight[i*WW +: WW];
        if (swap_req && swap_ok) active[i] <= shadow[i];
        if (dv_reg) acc[i] <= is_final ? '0 : result[i];
      end
      if (dv_reg) cnt <= is_final ? '0 : cnt_inc[CNT_W-1:0];
      if (swap_req) swap_pending_r <= !swap_ok;
    end
  end

  // Result register: a new result always wins; overwriting an unconsumed one
  // is flagged sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg     <= '0;
      sum_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (is_final) begin
      sum_reg     <= sat_packed;
      sum_valid_r <= 1'b1;
      if (sum_valid_r && !bus.out_ready) ovf_r <= 1'b1;
    end else if (sum_valid_r && bus.out_ready) begin
      sum_valid_r <= 1'b0;
    end
  end

  assign bus.data_out       = data_reg;
  assign bus.data_out_valid = dv_reg;
  assign bus.sum_out        = sum_reg;
  assign bus.sum_valid      = sum_valid_r;
  assign bus.swap_pending   = swap_pending_r;
  assign bus.ovf_sticky     = ovf_r;

endmodule
